// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// sharing one timeout-guarded memory port between fetch and load/store, with sticky trap flags.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        illegal_instr,
  output logic        bus_error,
  output logic [2:0]  state
);
  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    opcode_q, opcode_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          illegal_q, illegal_d;
  logic          bus_err_q, bus_err_d;
  logic [2:0]    imm_type;
  logic          known_op;
  logic          unused_bits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      funct3_q  <= '0;
      tmo_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct3_q  <= funct3_d;
      tmo_q     <= tmo_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Immediate format and legality come only from the latched opcode.
  always_comb begin
    imm_type = 3'd0;
    known_op = 1'b1;
    case (opcode_q)
      OP_IMM, OP_LOAD, OP_JALR: imm_type = 3'd1;
      OP_STORE:                 imm_type = 3'd2;
      OP_BRANCH:                imm_type = 3'd3;
      OP_LUI, OP_AUIPC:         imm_type = 3'd4;
      OP_JAL:                   imm_type = 3'd5;
      OP_R:                     imm_type = 3'd0;
      default:                  known_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct3_d  = funct3_q;
    tmo_d     = '0;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    imm_sel   = 3'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;

    case (state_q)
      IDLE: state_d = FETCH;

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          opcode_d = instr[6:0];
          funct3_d = instr[14:12];
          state_d  = DECODE;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      DECODE: begin
        imm_sel = imm_type;
        if (!known_op) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        imm_sel = imm_type;
        state_d = WB;
        case (opcode_q)
          OP_R:   alu_op = 2'd1;
          OP_IMM: begin alu_op = 2'd1; alu_src_b = 2'd1; end
          OP_LOAD, OP_STORE: begin alu_src_b = 2'd1; state_d = MEM; end
          OP_LUI:   begin alu_src_a = 2'd2; alu_src_b = 2'd1; end
          OP_AUIPC: begin alu_src_a = 2'd1; alu_src_b = 2'd1; end
          OP_BRANCH: begin
            alu_op  = 2'd2;
            state_d = FETCH;
            if (branch_taken) begin
              pc_write = 1'b1;
              pc_src   = 2'd1;
            end
          end
          OP_JAL:  begin pc_write = 1'b1; pc_src = 2'd1; end
          OP_JALR: begin alu_src_b = 2'd1; pc_write = 1'b1; pc_src = 2'd2; end
          default: state_d = TRAP;
        endcase
      end

      // Address and write strobe stay stable until the transfer is accepted.
      MEM: begin
        imm_sel  = imm_type;
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode_q == OP_STORE);
        if (mem_ready) begin
          state_d = (opcode_q == OP_STORE) ? FETCH : WB;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = TRAP;
          bus_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      WB: begin
        imm_sel   = imm_type;
        reg_write = 1'b1;
        state_d   = FETCH;
        if (opcode_q == OP_LOAD)
          wb_sel = 2'd1;
        else if (opcode_q == OP_JAL || opcode_q == OP_JALR)
          wb_sel = 2'd2;
      end

      TRAP: state_d = TRAP;

      default: state_d = IDLE;
    endcase
  end

  assign illegal_instr = illegal_q;
  assign bus_error     = bus_err_q;
  assign state         = state_q;
  assign unused_bits   = ^{instr[31:15], instr[11:7], funct3_q};
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Testbench for multicycle_control_fsm: directed vector table, multi-cycle corner sequences
// and randomized instruction streams checked against a per-instruction trace model.
module tb_multicycle_control_fsm;
  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irl;
    logic       pcw;
    logic [1:0] pcs;
    logic [2:0] imm;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] wbs;
    logic       ill;
    logic       berr;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    logic        rdy;
    logic        bt;
    outs_t       exp;
  } vec_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req, mem_we, addr_sel, ir_load, pc_write, reg_write;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0]  imm_sel, state;
  logic        illegal_instr, bus_error;
  outs_t       act;

  int   checks   = 0;
  int   failures = 0;
  vec_t tableQ[$];
  vec_t planQ[$];
  logic [6:0] legalOps [9] = '{OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
                               OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL};

  always #5 clk = ~clk;

  multicycle_control_fsm #(.MEM_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .imm_sel(imm_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_write(reg_write), .wb_sel(wb_sel), .illegal_instr(illegal_instr),
    .bus_error(bus_error), .state(state)
  );

  assign act = {state, mem_req, mem_we, addr_sel, ir_load, pc_write, pc_src, imm_sel,
                alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, illegal_instr, bus_error};

  // Column order: state, req, we, asel, irl, pcw, pcs, imm, src_a, src_b, alu_op, rw, wb_sel, ill, berr
  function automatic outs_t e(input logic [2:0] st, input logic req, we, asel, irl, pcw,
                              input logic [1:0] pcs, input logic [2:0] imm,
                              input logic [1:0] sa, sb, aop, input logic rw,
                              input logic [1:0] wbs, input logic ill, berr);
    return {st, req, we, asel, irl, pcw, pcs, imm, sa, sb, aop, rw, wbs, ill, berr};
  endfunction

  function automatic outs_t idle();
    return e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic outs_t fetchWait();
    return e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic outs_t fetchOk();
    return e(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [2:0] modelImm(input logic [6:0] op);
    if (op == OP_IMM || op == OP_LOAD || op == OP_JALR) return 3'd1;
    if (op == OP_STORE)  return 3'd2;
    if (op == OP_BRANCH) return 3'd3;
    if (op == OP_LUI || op == OP_AUIPC) return 3'd4;
    if (op == OP_JAL)    return 3'd5;
    return 3'd0;
  endfunction

  task automatic addTable(input logic [31:0] i, input logic r, input logic b, input outs_t x);
    vec_t v;
    v.instr = i; v.rdy = r; v.bt = b; v.exp = x;
    tableQ.push_back(v);
  endtask

  task automatic addPlan(input logic [31:0] i, input logic r, input logic b, input outs_t x);
    vec_t v;
    v.instr = i; v.rdy = r; v.bt = b; v.exp = x;
    planQ.push_back(v);
  endtask

  task automatic applyStimulus(input logic [31:0] i, input logic r, input logic b);
    @(negedge clk);
    instr = i;
    mem_ready = r;
    branch_taken = b;
    #1;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h required=%h (state %0d, required state %0d)",
               name, act, exp, act.st, exp.st);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("reset state", idle());
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Expected cycle-by-cycle trace of one instruction, derived from the per-class rules.
  task automatic planInstr(input logic [6:0] op, input int wf, input int wm, input logic bt);
    logic [31:0] r;
    logic [2:0]  imm;
    logic        isLoad, isStore;
    logic [1:0]  wbs;
    outs_t       x;
    imm     = modelImm(op);
    isLoad  = (op == OP_LOAD);
    isStore = (op == OP_STORE);
    for (int i = 0; i < wf; i++)
      addPlan($urandom(), 1'b0, 1'($urandom_range(0, 1)), fetchWait());
    r = $urandom();
    addPlan({r[31:7], op}, 1'b1, 1'($urandom_range(0, 1)), fetchOk());
    addPlan($urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            e(2, 0, 0, 0, 0, 0, 0, imm, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      OP_R:      x = e(3, 0, 0, 0, 0, 0, 0, imm, 0, 0, 1, 0, 0, 0, 0);
      OP_IMM:    x = e(3, 0, 0, 0, 0, 0, 0, imm, 0, 1, 1, 0, 0, 0, 0);
      OP_LUI:    x = e(3, 0, 0, 0, 0, 0, 0, imm, 2, 1, 0, 0, 0, 0, 0);
      OP_AUIPC:  x = e(3, 0, 0, 0, 0, 0, 0, imm, 1, 1, 0, 0, 0, 0, 0);
      OP_BRANCH: x = e(3, 0, 0, 0, 0, bt, bt ? 2'd1 : 2'd0, imm, 0, 0, 2, 0, 0, 0, 0);
      OP_JAL:    x = e(3, 0, 0, 0, 0, 1, 1, imm, 0, 0, 0, 0, 0, 0, 0);
      OP_JALR:   x = e(3, 0, 0, 0, 0, 1, 2, imm, 0, 1, 0, 0, 0, 0, 0);
      default:   x = e(3, 0, 0, 0, 0, 0, 0, imm, 0, 1, 0, 0, 0, 0, 0);
    endcase
    addPlan($urandom(), 1'($urandom_range(0, 1)), bt, x);
    if (isLoad || isStore) begin
      x = e(4, 1, isStore, 1, 0, 0, 0, imm, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < wm; i++)
        addPlan($urandom(), 1'b0, 1'($urandom_range(0, 1)), x);
      addPlan($urandom(), 1'b1, 1'($urandom_range(0, 1)), x);
    end
    if (op != OP_BRANCH && !isStore) begin
      wbs = isLoad ? 2'd1 : ((op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0);
      addPlan($urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              e(5, 0, 0, 0, 0, 0, 0, imm, 0, 0, 0, 1, wbs, 0, 0));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    instr = '0;
    mem_ready = 1'b0;
    branch_taken = 1'b0;

    // addi x1,x0,5 with immediate memory; DECODE sees garbage on instr and a stray mem_ready
    addTable(32'h0000_0000, 0, 0, idle());
    addTable(32'h0050_0093, 1, 0, fetchOk());
    addTable(32'hFFFF_FFFF, 1, 0, e(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0050_0093, 0, 0, e(3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0));
    addTable(32'h0050_0093, 0, 0, e(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    // lw with three wait cycles in MEM
    addTable(32'h0040_A103, 1, 0, fetchOk());
    addTable(32'h0040_A103, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0040_A103, 0, 0, e(3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      addTable(32'h0040_A103, 0, 0, e(4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0040_A103, 1, 0, e(4, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0040_A103, 0, 0, e(5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0));
    // beq taken
    addTable(32'h0000_0463, 1, 0, fetchOk());
    addTable(32'h0000_0463, 0, 1, e(2, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0000_0463, 0, 1, e(3, 0, 0, 0, 0, 1, 1, 3, 0, 0, 2, 0, 0, 0, 0));
    // sw
    addTable(32'h0020_A023, 1, 0, fetchOk());
    addTable(32'h0020_A023, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0020_A023, 0, 0, e(3, 0, 0, 0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0));
    addTable(32'h0020_A023, 1, 0, e(4, 1, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0));
    // jal
    addTable(32'h0100_00EF, 1, 0, fetchOk());
    addTable(32'h0100_00EF, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0100_00EF, 0, 0, e(3, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'h0100_00EF, 0, 0, e(5, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 1, 2, 0, 0));
    // unknown opcode traps and stays trapped despite mem_ready
    addTable(32'hFFFF_FFFF, 1, 0, fetchOk());
    addTable(32'hFFFF_FFFF, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    addTable(32'hFFFF_FFFF, 1, 0, e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    addTable(32'h0050_0093, 1, 0, e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    doReset();
    foreach (tableQ[i]) begin
      applyStimulus(tableQ[i].instr, tableQ[i].rdy, tableQ[i].bt);
      checkOutput($sformatf("table[%0d]", i), tableQ[i].exp);
    end

    // Asynchronous reset while FETCH is requesting
    doReset();
    applyStimulus(32'h0, 0, 0);
    checkOutput("idle after reset", idle());
    applyStimulus(32'h0050_0093, 0, 0);
    checkOutput("fetch waiting", fetchWait());
    #1 reset = 1'b1;
    #1 checkOutput("async reset mid-fetch", idle());
    #1 reset = 1'b0;
    applyStimulus(32'h0050_0093, 0, 0);
    checkOutput("fetch after reset release", fetchWait());

    // mem_ready arriving in the 16th wait cycle wins over the timeout
    doReset();
    applyStimulus(32'h0, 0, 0);
    for (int k = 0; k < 15; k++) begin
      applyStimulus(32'h0050_0093, 0, 0);
      checkOutput($sformatf("late fetch wait %0d", k), fetchWait());
    end
    applyStimulus(32'h0050_0093, 1, 0);
    checkOutput("ready on limit cycle", fetchOk());
    applyStimulus(32'h0, 0, 0);
    checkOutput("decode after limit-cycle ready", e(2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

    // Fetch never answered: bus error trap after 16 cycles, later ready ignored
    doReset();
    applyStimulus(32'h0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(32'h0050_0093, 0, 0);
      checkOutput($sformatf("timeout wait %0d", k), fetchWait());
    end
    applyStimulus(32'h0050_0093, 0, 0);
    checkOutput("bus error trap", e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(32'h0050_0093, 1, 0);
    checkOutput("trap ignores ready", e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    applyStimulus(32'h0050_0093, 0, 0);
    checkOutput("trap absorbing", e(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Random legal instruction stream with random wait states
    doReset();
    addPlan(32'h0, 1'($urandom_range(0, 1)), 0, idle());
    for (int n = 0; n < 40; n++)
      planInstr(legalOps[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
    foreach (planQ[i]) begin
      applyStimulus(planQ[i].instr, planQ[i].rdy, planQ[i].bt);
      checkOutput($sformatf("random[%0d]", i), planQ[i].exp);
    end

    doReset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
